// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, a carry-flag register and an
// iterative shift-add multiplier; results are held until the consumer takes them.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [3:0]       OP,
    input  logic             SC_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Even,
    output logic             Carry,
    output logic             Illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_ADC = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zero, r_even, r_carry, r_illegal;
    logic [WIDTH-1:0] r_ma, r_mb, r_acc;
    logic [SHW-1:0]   r_cnt;

    logic             w_accept;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_bit, w_res, w_acc_n, w_mul_first;
    logic             w_c, w_ill;

    assign in_ready  = (r_state == S_IDLE) || (r_state == S_DONE && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign Out       = r_out;
    assign Zero      = r_zero;
    assign Even      = r_even;
    assign Carry     = r_carry;
    assign Illegal   = r_illegal;

    assign w_sum  = {1'b0, InputA} + {1'b0, InputB} + {{WIDTH{1'b0}}, (OP == OP_ADC) & r_carry};
    assign w_diff = {1'b0, InputA} - {1'b0, InputB};
    assign w_bit  = {{(WIDTH-1){1'b0}}, 1'b1} << InputB[SHW-1:0];

    // Multiplier consumes one bit of B per cycle; the first bit is folded into the accept edge
    assign w_mul_first = InputB[0] ? InputA : '0;
    assign w_acc_n     = r_acc + (r_mb[0] ? r_ma : '0);

    always_comb begin
        w_res = '0;
        w_c   = r_carry;
        w_ill = 1'b0;
        case (OP)
            4'd0, 4'd7: begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
            4'd1:       begin w_res = {InputA[WIDTH-2:0], SC_in}; w_c = InputA[WIDTH-1]; end
            4'd2:       begin w_res = {1'b0, InputA[WIDTH-1:1]}; w_c = InputA[0]; end
            4'd3:       w_res = InputA ^ InputB;
            4'd4:       w_res = {{(WIDTH-1){1'b0}}, InputA != InputB};
            4'd5:       w_res = {{(WIDTH-1){1'b0}}, InputA == InputB};
            4'd6:       w_res = InputA & w_bit;
            4'd8:       begin w_res = w_diff[WIDTH-1:0]; w_c = ~w_diff[WIDTH]; end
            4'd9:       w_res = InputA & InputB;
            4'd10:      w_res = InputA | InputB;
            4'd11:      w_res = '0;
            default:    w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_even      <= 1'b0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (OP == OP_MUL) begin
                            r_ma        <= InputA << 1;
                            r_mb        <= InputB >> 1;
                            r_acc       <= w_mul_first;
                            r_cnt       <= SHW'(WIDTH - 1);
                            r_out_valid <= 1'b0;
                            r_state     <= S_MUL;
                        end else begin
                            r_out       <= w_res;
                            r_zero      <= (w_res == '0);
                            r_even      <= ~w_res[0];
                            r_carry     <= w_c;
                            r_illegal   <= w_ill;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end else if (r_state == S_DONE && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (r_cnt == SHW'(1)) begin
                        r_out       <= w_acc_n;
                        r_zero      <= (w_acc_n == '0);
                        r_even      <= ~w_acc_n[0];
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc <= w_acc_n;
                        r_ma  <= r_ma << 1;
                        r_mb  <= r_mb >> 1;
                        r_cnt <= r_cnt - SHW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors on an 8-bit and a 16-bit instance,
// expected results queued at issue and checked by a monitor thread on each output transfer.
`timescale 1ns/1ps
module tb_alu_pipe;
    typedef struct packed {
        logic [15:0] out;
        logic        z, e, c, il;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    always #5 Clk = ~Clk;

    logic        iv8 = 0, ir8, sc8 = 0, ov8, or8 = 1, z8, e8, c8, il8;
    logic [7:0]  a8 = 0, b8 = 0, o8;
    logic [3:0]  op8 = 0;
    logic        iv16 = 0, ir16, sc16 = 0, ov16, or16 = 1, z16, e16, c16, il16;
    logic [15:0] a16 = 0, b16 = 0, o16;
    logic [3:0]  op16 = 0;

    alu_pipe #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset(Reset), .in_valid(iv8), .in_ready(ir8), .InputA(a8), .InputB(b8),
        .OP(op8), .SC_in(sc8), .out_valid(ov8), .out_ready(or8), .Out(o8), .Zero(z8),
        .Even(e8), .Carry(c8), .Illegal(il8));

    alu_pipe #(.WIDTH(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .in_valid(iv16), .in_ready(ir16), .InputA(a16), .InputB(b16),
        .OP(op16), .SC_in(sc16), .out_valid(ov16), .out_ready(or16), .Out(o16), .Zero(z16),
        .Even(e16), .Carry(c16), .Illegal(il16));

    exp_t q8[$], q16[$];
    int   n_vec = 0, n_err = 0;
    int   w;

    function automatic exp_t mk(input logic [15:0] o, input logic z, e, c, il);
        mk = '{out: o, z: z, e: e, c: c, il: il};
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input bit s16, input logic [3:0] op, input logic [15:0] a, b,
                         input logic sc, input bit push, input exp_t e, output int waits);
        logic rdy;
        waits = 0;
        if (s16) begin iv16 = 1; op16 = op; a16 = a; b16 = b; sc16 = sc; end
        else begin iv8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; sc8 = sc; end
        @(negedge Clk);
        rdy = s16 ? ir16 : ir8;
        while (!rdy && waits < 50) begin
            waits++;
            @(negedge Clk);
            rdy = s16 ? ir16 : ir8;
        end
        if (!rdy) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", waits);
        end
        if (push) begin
            if (s16) q16.push_back(e); else q8.push_back(e);
        end
        @(posedge Clk); #1;
        // scramble operands after accept: results must come from captured values
        if (s16) begin iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); op16 = 4'($urandom); end
        else begin iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom); end
    endtask

    task automatic i8(input logic [3:0] op, input logic [7:0] a, b, input logic sc, input exp_t e);
        int wt;
        issue(1'b0, op, {8'h0, a}, {8'h0, b}, sc, 1'b1, e, wt);
    endtask

    initial begin
        exp_t ex;
        fork
            forever begin
                @(negedge Clk);
                if (!Reset && ov8 && or8) begin
                    if (q8.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL out8_unexpected: Out=0x%0h with empty queue", o8);
                    end else begin
                        ex = q8.pop_front();
                        chk("out8", {8'h0, o8, z8, e8, c8, il8}, {4'h0, ex});
                    end
                end
                if (!Reset && ov16 && or16) begin
                    if (q16.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL out16_unexpected: Out=0x%0h with empty queue", o16);
                    end else begin
                        ex = q16.pop_front();
                        chk("out16", {o16, z16, e16, c16, il16}, {ex});
                    end
                end
            end
        join_none

        repeat (2) @(posedge Clk);
        #1 Reset = 0;
        chk("reset_state", {14'h0, ov8, ir8, o8, z8, e8}, {14'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        chk("reset_flags", {17'h0, c8, il8, ov16}, 20'h0);

        // basic add and single-cycle latency
        i8(4'd0, 8'h01, 8'h01, 0, mk(16'h02, 0, 1, 0, 0));
        chk("add_latency", {19'h0, ov8}, 20'h1);
        // carry chain
        i8(4'd0, 8'hFF, 8'h01, 0, mk(16'h00, 1, 1, 1, 0));
        i8(4'd7, 8'h01, 8'h01, 0, mk(16'h03, 0, 0, 0, 0));
        i8(4'd8, 8'h03, 8'h05, 0, mk(16'hFE, 0, 1, 0, 0));
        // logic / compare / shift ops back to back
        i8(4'd6, 8'h07, 8'h02, 0, mk(16'h04, 0, 1, 0, 0));
        i8(4'd5, 8'h05, 8'h05, 0, mk(16'h01, 0, 0, 0, 0));
        i8(4'd5, 8'h05, 8'h06, 0, mk(16'h00, 1, 1, 0, 0));
        i8(4'd4, 8'h00, 8'h01, 0, mk(16'h01, 0, 0, 0, 0));
        i8(4'd4, 8'h03, 8'h03, 0, mk(16'h00, 1, 1, 0, 0));
        i8(4'd3, 8'h02, 8'h06, 0, mk(16'h04, 0, 1, 0, 0));
        i8(4'd1, 8'h04, 8'h00, 1, mk(16'h09, 0, 0, 0, 0));
        i8(4'd2, 8'h05, 8'h00, 0, mk(16'h02, 0, 1, 1, 0));
        i8(4'd9, 8'hF0, 8'h3C, 0, mk(16'h30, 0, 1, 1, 0));
        i8(4'd10, 8'hF0, 8'h0F, 0, mk(16'hFF, 0, 0, 1, 0));
        i8(4'd7, 8'h10, 8'h20, 0, mk(16'h31, 0, 0, 0, 0));
        // multiply: fixed latency, in_ready low while busy
        i8(4'd11, 8'd13, 8'd11, 0, mk(16'h8F, 0, 0, 0, 0));
        chk("mul_busy0", {18'h0, ov8, ir8}, 20'h0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("mul_busy%0d", k), {18'h0, ov8, ir8}, 20'h0);
        end
        @(posedge Clk); #1;
        chk("mul_latency", {19'h0, ov8}, 20'h1);
        i8(4'd11, 8'h10, 8'h10, 0, mk(16'h00, 1, 1, 0, 0));
        i8(4'd11, 8'hFF, 8'hFF, 0, mk(16'h01, 0, 0, 0, 0));
        i8(4'd8, 8'h05, 8'h03, 0, mk(16'h02, 0, 1, 1, 0));

        // output stall then drain-and-accept in the same cycle
        repeat (3) @(posedge Clk);
        #1 or8 = 0;
        i8(4'd0, 8'h02, 8'h03, 0, mk(16'h05, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            chk($sformatf("stall%0d", k), {10'h0, ov8, ir8, o8}, {10'h0, 1'b1, 1'b0, 8'h05});
        end
        or8 = 1;
        issue(1'b0, 4'd3, 16'h00FF, 16'h000F, 0, 1'b1, mk(16'hF0, 0, 1, 0, 0), w);
        chk("drain_accept_waits", 20'(w), 20'd0);
        chk("drain_accept_valid", {19'h0, ov8}, 20'h1);

        // reset in the middle of a multiply discards it
        issue(1'b0, 4'd11, 16'd13, 16'd11, 0, 1'b0, mk(16'h0, 0, 0, 0, 0), w);
        repeat (3) @(posedge Clk);
        #1 Reset = 1;
        @(posedge Clk); #1;
        chk("mid_mul_reset", {8'h0, ov8, ir8, o8, c8, il8}, {8'h0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
        Reset = 0;

        // reserved opcodes keep the carry flag
        i8(4'd12, 8'h05, 8'h05, 0, mk(16'h00, 1, 1, 0, 1));
        i8(4'd0, 8'hFF, 8'h01, 0, mk(16'h00, 1, 1, 1, 0));
        i8(4'd13, 8'h12, 8'h34, 0, mk(16'h00, 1, 1, 1, 1));
        i8(4'd0, 8'h01, 8'h01, 0, mk(16'h02, 0, 1, 0, 0));

        // 16-bit instance
        issue(1'b1, 4'd0, 16'hFFFF, 16'h0001, 0, 1'b1, mk(16'h0000, 1, 1, 1, 0), w);
        issue(1'b1, 4'd1, 16'h8000, 16'h0000, 0, 1'b1, mk(16'h0000, 1, 1, 1, 0), w);
        issue(1'b1, 4'd6, 16'hFFFF, 16'h000F, 0, 1'b1, mk(16'h8000, 0, 1, 1, 0), w);
        issue(1'b1, 4'd11, 16'h0123, 16'h0045, 0, 1'b1, mk(16'h4E6F, 0, 0, 1, 0), w);

        for (int k = 0; k < 100 && (q8.size() != 0 || q16.size() != 0); k++) @(posedge Clk);
        repeat (2) @(posedge Clk);
        chk("queues_drained", 20'(q8.size() + q16.size()), 20'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
